// File: rtl/mul_multicycle.sv
// ---------------------------------------------------------------------------
// mul_multicycle
//
// Iterative shift-add multiplier.
// - Computes the low 32 bits of a*b, one multiplier bit per cycle.
// - Sits in the CPU execute path:
//     * `stall` freezes the PC register while a multiply is in flight.
//     * `done`/`result` drive the register-file write port.
// - The low 32 bits of a product are the same for signed and unsigned
//   operands, so there is no sign handling.
//
// Ports:
//   clk     in   1   rising-edge clock
//   rst     in   1   synchronous active-high reset
//   start   in   1   current instruction is a multiply (held while current)
//   a       in  32   multiplicand, sampled on the accepting cycle only
//   b       in  32   multiplier, sampled on the accepting cycle only
//   result  out 32   registered product, valid with done, held until next
//   done    out  1   one-cycle pulse, product ready / regfile write enable
//   busy    out  1   registered, high while iterating
//   stall   out  1   combinational, PC register enable is ~stall
//
// Optional feature:
//   MUL_EARLY_EXIT_EN - when defined, iteration stops as soon as the
//   remaining multiplier bits are all zero. The result is unchanged; only
//   the latency gets shorter.
// ---------------------------------------------------------------------------
module mul_multicycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        stall
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] acc;
    logic [4:0]  cnt;

    logic [31:0] acc_next;
    logic        last_iter;

    // Accumulator value after this cycle's conditional add. It is also what
    // gets captured into result on the final iteration, so that the last
    // partial product is not lost.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Decide whether the current BUSY cycle is the final iteration.
`ifdef MUL_EARLY_EXIT_EN
    // Once the bits still to be consumed are all zero, further iterations
    // would only add zero, so the product is already complete.
    always_comb begin
        last_iter = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
    end
`else
    always_comb begin
        last_iter = (cnt == 5'd31);
    end
`endif

    // The PC must not advance on the accepting cycle or while iterating.
    // Reset overrides so that the CPU is never frozen while in reset.
    always_comb begin
        stall = !rst && (((state == IDLE) && start) || (state == BUSY));
    end

    // Control FSM and datapath.
    // - done and busy are registered alongside the state, so they line up
    //   exactly with DONE and BUSY.
    // - DONE always returns to IDLE. A start still high there belongs to the
    //   instruction being retired, and must not trigger a second multiply.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= 32'd0;
            done   <= 1'b0;
            busy   <= 1'b0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 32'd0;
            cnt    <= 5'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a;
                        mplier <= b;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 5'd1;
                    if (last_iter) begin
                        result <= acc_next;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_multicycle.sv
// ---------------------------------------------------------------------------
// tb_mul_multicycle
//
// Self-checking bench for mul_multicycle.
// - Expected values are built inside the bench:
//     * the product comes from plain 32-bit arithmetic;
//     * the latency comes from the index of the highest set bit of b.
// - Covers:
//     * reset and idle behaviour;
//     * a table of fixed vectors;
//     * randomized operands;
//     * hand-written back-to-back and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_mul_multicycle;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        stall;

    int checks;
    int passes;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] prod;
        string       name;
    } vec_t;

    vec_t vecs[$];

    mul_multicycle dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .result (result),
        .done   (done),
        .busy   (busy),
        .stall  (stall)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge. Inputs are driven and
    // outputs sampled here, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare one value against its expected value and record the outcome.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h",
                     name, actual, expected);
        end
    endtask

    // Cycles from the accepting cycle to the done pulse.
    // - Without early exit: always 33.
    // - With early exit: the multiplier runs for (highest set bit of b) + 1
    //   cycles, and a zero multiplier still takes one cycle.
    function automatic int expLatency(input logic [31:0] bv);
`ifdef MUL_EARLY_EXIT_EN
        int k;
        k = 0;
        for (int i = 0; i < 32; i++) begin
            if (bv[i]) k = i;
        end
        return k + 2;
`else
        return 33 + 0 * int'(bv[0]);
`endif
    endfunction

    // Issue one multiply in the current cycle, which must be an IDLE cycle.
    // - start is left high on return, and the bench sits in the done cycle.
    // - Operands are scrambled after acceptance; the DUT must ignore that.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] expProd, input string name);
        int n;
        int stallCnt;
        int busyCnt;
        int lat;
        lat      = expLatency(bv);
        start    = 1'b1;
        a        = av;
        b        = bv;
        n        = 0;
        stallCnt = 0;
        busyCnt  = 0;
        #1;
        if (stall) stallCnt++;
        while (n < 40) begin
            tick();
            n++;
            a = $urandom;
            b = $urandom;
            if (done) break;
            if (stall) stallCnt++;
            if (busy) busyCnt++;
        end
        checkOutput({name, " latency"}, n, lat);
        checkOutput({name, " result"}, result, expProd);
        checkOutput({name, " stall count"}, stallCnt, lat);
        checkOutput({name, " busy count"}, busyCnt, lat - 1);
        checkOutput({name, " stall in done"}, {31'd0, stall}, 32'd0);
        checkOutput({name, " busy in done"}, {31'd0, busy}, 32'd0);
    endtask

    // Drop start after a completion, then check that done was only a
    // one-cycle pulse and that result is held.
    task automatic retire(input logic [31:0] expProd, input string name);
        start = 1'b0;
        tick();
        checkOutput({name, " done pulse ends"}, {31'd0, done}, 32'd0);
        checkOutput({name, " result held"}, result, expProd);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        passes = 0;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 32'd0;
        b      = 32'd0;

        vecs.push_back('{32'd7,        32'd6,        32'd42,         "7x6"});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   "wrap"});
        vecs.push_back('{32'h12345678, 32'd0,        32'd0,          "zero b"});
        vecs.push_back('{32'd0,        32'h80000001, 32'd0,          "zero a"});
        vecs.push_back('{32'h80000000, 32'd2,        32'd0,          "msb shift out"});
        vecs.push_back('{32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE,   "minus one x2"});
        vecs.push_back('{32'h12345678, 32'h10,       32'h23456780,   "shift by 16"});
        vecs.push_back('{32'd1000,     32'd1000,     32'd1000000,    "1000 squared"});
        vecs.push_back('{32'd3,        32'h80000000, 32'h80000000,   "top bit b"});

        // Reset, then idle with start low for 10 cycles.
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle result", result, 32'd0);
            checkOutput("idle done", {31'd0, done}, 32'd0);
            checkOutput("idle busy", {31'd0, busy}, 32'd0);
            checkOutput("idle stall", {31'd0, stall}, 32'd0);
        end

        // Fixed vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].name);
            retire(vecs[i].prod, vecs[i].name);
        end

        // Randomized operands. The multiplier is shifted by a random amount
        // so that its highest set bit, and hence the early-exit latency,
        // varies.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            applyStimulus(ra, rb, ra * rb, "random");
            retire(ra * rb, "random");
        end

        // Back-to-back with start continuously high.
        // - Second acceptance is the cycle after DONE.
        // - Exactly two done pulses.
        applyStimulus(32'd3, 32'd5, 32'd15, "b2b first");
        a = 32'h10000;
        b = 32'h10000;
        tick();
        checkOutput("b2b idle done low", {31'd0, done}, 32'd0);
        checkOutput("b2b second accept stall", {31'd0, stall}, 32'd1);
        checkOutput("b2b result held", result, 32'd15);
        applyStimulus(32'h10000, 32'h10000, 32'd0, "b2b second");
        retire(32'd0, "b2b second");

        // Leave a nonzero result behind so that the reset clear is visible.
        applyStimulus(32'd11, 32'd13, 32'd143, "pre reset");
        retire(32'd143, "pre reset");

        // Reset mid-operation: accept at T, assert rst during T+10.
        start = 1'b1;
        a     = 32'h12345678;
        b     = 32'hFFFFFFFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            a = $urandom;
        end
        rst = 1'b1;
        #1;
        checkOutput("stall during reset", {31'd0, stall}, 32'd0);
        tick();
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            tick();
            checkOutput("no done after abort", {31'd0, done}, 32'd0);
        end
        applyStimulus(32'd9, 32'd9, 32'd81, "9x9 after reset");
        retire(32'd81, "9x9 after reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
